// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch controller.
//   fetch_state_e : request FSM (IDLE / REQ / WAIT / DRAIN)
//   fetch_entry_t : one buffered instruction {pc, inst}
//   RESET_PC      : fetch address after reset
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // nothing outstanding
    S_REQ   = 2'd1,  // request held, waiting for grant
    S_WAIT  = 2'd2,  // one granted request, response will be kept
    S_DRAIN = 2'd3   // one granted request, response will be dropped
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC = 32'd0;

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: DEPTH-entry FIFO of fetched {pc, inst} pairs toward decode.
//   clk, rst_n            : clock, async active-low reset
//   i_push/i_push_pc/inst : write one entry (caller guarantees space)
//   i_pop                 : consume head (caller guarantees non-empty)
//   i_flush               : drop all entries; wins over push
//   o_count               : registered occupancy
//   o_head_valid/pc/inst  : head entry, driven from flops only (no bypass)
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [31:0]                i_push_pc,
  input  logic [31:0]                i_push_inst,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_head_valid,
  output logic [31:0]                o_head_pc,
  output logic [31:0]                o_head_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_rptr, r_wptr;
  logic [CW-1:0]  r_count;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= '{pc: i_push_pc, inst: i_push_inst};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (i_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != '0);
  assign o_head_pc    = r_mem[r_rptr].pc;
  assign o_head_inst  = r_mem[r_rptr].inst;

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller between PC register, IMEM and decode.
//   clk, rst_n                     : clock, async active-low reset
//   i_pc_if / o_pc_en              : fetch address in, PC advance/load enable out
//   i_redirect                     : taken branch/jump; flushes wrong-path work
//   o_imem_req/o_imem_addr/i_imem_gnt : request handshake (addr = i_pc_if)
//   i_imem_rvalid/i_imem_rdata     : in-order response, >=1 cycle after grant
//   o_inst_valid/o_inst/o_inst_pc/i_inst_ready : queue head toward decode
//   o_perf_fetched/o_perf_flushed  : counters, live only with IFETCH_PERF_EN
// Optional feature macro: IFETCH_PERF_EN (undefined: perf ports tied to 0).
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc_if,
  output logic        o_pc_en,
  input  logic        i_redirect,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_flushed
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state, w_state_nxt;
  logic [31:0]   r_req_addr;
  logic [CW-1:0] w_occ;
  logic [CW:0]   w_need;
  logic          w_pop, w_credit, w_free;
  logic          w_req, w_gnt, w_push, w_drop;

  assign w_pop = o_inst_valid & i_inst_ready;

  // Entries the queue will hold if we issue now: an in-flight kept response
  // still needs a slot even if it is landing this very cycle.
  assign w_need   = {1'b0, w_occ} - (CW+1)'(w_pop) + (CW+1)'(r_state == S_WAIT);
  assign w_credit = (w_need < (CW+1)'(DEPTH));

  // Port is free when idle, or when the single outstanding response lands now.
  assign w_free = (r_state == S_IDLE) |
                  (((r_state == S_WAIT) | (r_state == S_DRAIN)) & i_imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req_addr <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt) r_req_addr <= i_pc_if;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_gnt       = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    o_pc_en     = 1'b0;

    // rst_n gating keeps every output low while reset is held.
    if (rst_n && !i_redirect)
      w_req = (r_state == S_REQ) | (w_free & w_credit);
    w_gnt   = w_req & i_imem_gnt;
    o_pc_en = w_gnt | (rst_n & i_redirect);
    w_push  = (r_state == S_WAIT) & i_imem_rvalid & ~i_redirect;
    w_drop  = (r_state == S_DRAIN) & i_imem_rvalid;

    unique case (r_state)
      S_IDLE, S_REQ:
        w_state_nxt = w_gnt ? S_WAIT : (w_req ? S_REQ : S_IDLE);
      S_WAIT:
        if (i_imem_rvalid)   w_state_nxt = w_gnt ? S_WAIT : (w_req ? S_REQ : S_IDLE);
        else if (i_redirect) w_state_nxt = S_DRAIN;
      S_DRAIN:
        if (i_imem_rvalid)   w_state_nxt = w_gnt ? S_WAIT : (w_req ? S_REQ : S_IDLE);
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = i_pc_if;

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_pc    (r_req_addr),
    .i_push_inst  (i_imem_rdata),
    .i_pop        (w_pop),
    .i_flush      (i_redirect),
    .o_count      (w_occ),
    .o_head_valid (o_inst_valid),
    .o_head_pc    (o_inst_pc),
    .o_head_inst  (o_inst)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0]   r_fetched, r_flushed;
  logic [CW-1:0] w_flush_cnt;

  // An entry popped in the redirect cycle was delivered, not flushed.
  assign w_flush_cnt = i_redirect ? (w_occ - CW'(w_pop)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetched <= '0;
      r_flushed <= '0;
    end else begin
      r_fetched <= r_fetched + 32'(w_pop);
      r_flushed <= r_flushed + 32'(w_flush_cnt) + 32'(w_drop);
    end
  end

  assign o_perf_fetched = r_fetched;
  assign o_perf_flushed = r_flushed;
`else
  assign o_perf_fetched = '0;
  assign o_perf_flushed = '0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed + random bench for ifetch_ctrl with a transaction-level
// reference (PC register, single-slot IMEM, expected instruction queue).
module tb_ifetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_pc_if = '0;
  logic        o_pc_en;
  logic        i_redirect = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst, o_inst_pc;
  logic        i_inst_ready = 1'b0;
  logic [31:0] o_perf_fetched, o_perf_flushed;

  ifetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_pc_if(i_pc_if), .o_pc_en(o_pc_en),
    .i_redirect(i_redirect), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready), .o_perf_fetched(o_perf_fetched),
    .o_perf_flushed(o_perf_flushed)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  int total = 0, bad = 0;

  // reference state
  ent_t        mq[$];          // instructions decode should see, in order
  logic [31:0] pc;             // PC register
  bit          slot_v, slot_live;
  int          slot_dly;
  logic [31:0] slot_addr, slot_data;
  bit          held;           // an ungranted request must stay up
  logic [31:0] m_fetched, m_flushed;
  int          grants;
  logic        last_req, last_pcen;
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic model_reset();
    mq.delete();
    pc = 32'd0; slot_v = 0; slot_live = 0; slot_dly = 0;
    held = 0; m_fetched = '0; m_flushed = '0;
  endtask

  task automatic chk_perf(input string tag);
`ifdef IFETCH_PERF_EN
    chk({tag, "_fetched"}, o_perf_fetched, m_fetched);
    chk({tag, "_flushed"}, o_perf_flushed, m_flushed);
`else
    chk({tag, "_fetched"}, o_perf_fetched, 32'd0);
    chk({tag, "_flushed"}, o_perf_flushed, 32'd0);
`endif
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cyc(input bit redir, input logic [31:0] tgt, input bit gnt,
                     input bit rdy, input int lat, input bit ovr);
    bit rv, pop, credit, exp_req, busy_after;
    int inflight;
    if (slot_v) slot_dly--;
    rv = slot_v && (slot_dly == 0);
    i_pc_if       = pc;
    i_redirect    = redir;
    i_inst_ready  = rdy;
    i_imem_gnt    = gnt;
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? slot_data : $urandom;
    #1;
    pop        = (mq.size() > 0) && rdy;
    inflight   = (slot_v && slot_live) ? 1 : 0;
    credit     = (mq.size() - int'(pop) + inflight) < DEPTH;
    busy_after = slot_v && !rv;
    exp_req    = !redir && (held || (!busy_after && credit));

    last_req = o_imem_req; last_addr = o_imem_addr; last_pcen = o_pc_en;
    chk("req", o_imem_req, exp_req);
    chk("pc_en", o_pc_en, redir || (exp_req && gnt));
    if (exp_req) chk("addr", o_imem_addr, pc);
    chk("inst_valid", o_inst_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("inst_pc", o_inst_pc, mq[0].pc);
      chk("inst", o_inst, mq[0].inst);
    end
    chk_perf("perf");

    // apply what the coming edge does
    if (pop) begin void'(mq.pop_front()); m_fetched++; end
    if (rv) begin
      if (!slot_live) m_flushed++;
      else if (!redir) mq.push_back('{pc: slot_addr, inst: slot_data});
      slot_v = 0;
    end
    if (redir) begin
      m_flushed += mq.size();
      mq.delete();
      slot_live = 0;
      pc = tgt;
    end
    if (exp_req && gnt) begin
      slot_v = 1; slot_live = 1; slot_dly = lat;
      slot_addr = pc;
      slot_data = ovr ? 32'h1234_5678 : imem_word(pc);
      pc = pc + 32'd4;
      grants++;
    end
    held = exp_req && !gnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int g0;
    bit seen;
    logic [31:0] p0;
    grants = 0;
    model_reset();

    // reset state
    #3;
    chk("rst_req", o_imem_req, 0);
    chk("rst_pc_en", o_pc_en, 0);
    chk("rst_valid", o_inst_valid, 0);
    chk("rst_inst", o_inst, 0);
    chk("rst_inst_pc", o_inst_pc, 0);
    chk_perf("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // streaming, single-cycle IMEM
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 1, 1, 0);
      if (i == 0) begin
        chk("first_req", last_req, 1);
        chk("first_addr", last_addr, 32'd0);
      end else begin
        chk("stream_valid", o_inst_valid, 1);
        chk("stream_pc", o_inst_pc, 32'(4 * (i - 1)));
        chk("stream_inst", o_inst, imem_word(32'(4 * (i - 1))));
      end
    end

    // decode stalled: credit allows exactly DEPTH grants
    cyc(1, 32'h100, 0, 0, 1, 0);
    g0 = grants;
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 1, 0);
    chk("stall_grants", 32'(grants - g0), 32'd2);
    chk("stall_req", last_req, 0);
    cyc(0, 0, 1, 1, 1, 0);
    chk("resume_req", last_req, 1);
    chk("resume_addr", last_addr, 32'h108);

    // grant delayed three cycles
    cyc(1, 32'h200, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1, 0);
      chk("hold_req", last_req, 1);
      chk("hold_addr", last_addr, 32'h200);
      chk("hold_pc_en", last_pcen, 0);
    end
    cyc(0, 0, 1, 1, 1, 0);
    chk("gnt_pc_en", last_pcen, 1);

    // redirect in WAIT with one entry queued; late response must vanish
    cyc(0, 0, 1, 0, 3, 1);
    p0 = o_perf_flushed;
    cyc(1, 32'h300, 0, 0, 1, 0);
    chk("flush_valid", o_inst_valid, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 1, 0);
      chk("no_late", {31'd0, o_inst_valid && (o_inst == 32'h1234_5678)}, 32'd0);
      if (last_req && !seen) begin
        seen = 1;
        chk("target_addr", last_addr, 32'h300);
      end
    end
    chk("target_req_seen", {31'd0, seen}, 32'd1);
`ifdef IFETCH_PERF_EN
    chk("flushed_delta", o_perf_flushed - p0, 32'd2);
`else
    chk("flushed_delta", o_perf_flushed - p0, 32'd0);
`endif

    // redirect coinciding with response
    cyc(1, 32'h400, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("post_rv_req", last_req, 1);
    chk("post_rv_addr", last_addr, 32'h400);

    // reset asserted while WAITing
    cyc(0, 0, 1, 1, 3, 0);
    #2;
    rst_n = 1'b0;
    i_imem_gnt = 0; i_imem_rvalid = 0; i_redirect = 0;
    #1;
    chk("mid_rst_req", o_imem_req, 0);
    chk("mid_rst_pc_en", o_pc_en, 0);
    chk("mid_rst_valid", o_inst_valid, 0);
    chk("mid_rst_inst", o_inst, 0);
    chk("mid_rst_inst_pc", o_inst_pc, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 1, 1, 1, 0);
    chk("after_rst_req", last_req, 1);
    chk("after_rst_addr", last_addr, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit rd;
      logic [31:0] tgt;
      rd  = ($urandom_range(0, 19) == 0);
      tgt = $urandom & 32'h0000_FFFC;
      cyc(rd, tgt, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
          $urandom_range(1, 3), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller. It consumes the fetch address held in the PC register and drives that register's enable. It issues requests to instruction memory over a grant/valid handshake and buffers returned instructions with their PCs in a small queue toward decode. It also discards wrong-path fetches when a branch or jump redirects the PC. It sits between the PC register, IMEM and the decode stage.

## Interface
- DEPTH, 2, instruction queue entries; power of two, 2..8
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- PC_IF  in  32  current fetch address from the PC register
- PC_EN  out  1  PC register enable: advance (PC+4) or load redirect target
- REDIRECT  in  1  taken branch/jump/JR this cycle; PC loads target at this edge
- IMEM_REQ  out  1  fetch request
- IMEM_ADDR  out  32  request address, equal to PC_IF
- IMEM_GNT  in  1  request accepted this cycle
- IMEM_RVALID  in  1  response data valid, in order, at least 1 cycle after grant
- IMEM_RDATA  in  32  instruction word
- INST_VALID  out  1  queue head valid
- INST  out  32  head instruction
- INST_PC  out  32  head instruction address
- INST_READY  in  1  decode accepts head
- PERF_FETCHED  out  32  delivered-instruction count (see Configuration)
- PERF_FLUSHED  out  32  discarded-fetch count (see Configuration)

## Operation
- FSM states:
  - IDLE: nothing outstanding.
  - REQ: IMEM_REQ held, awaiting grant.
  - WAIT: one request granted, awaiting response.
  - DRAIN: one granted request whose response must be discarded.
- At most one request is outstanding.
- Issue condition: not REDIRECT, and no outstanding request (or IMEM_RVALID this cycle in WAIT), and occ − pop + inflight < DEPTH.
  - occ is the registered queue count.
  - pop = INST_VALID & INST_READY.
  - inflight = 1 in WAIT.
- IMEM_REQ is asserted combinationally when the issue condition holds, or in REQ.
  - Once asserted and not granted, the FSM holds it in REQ regardless of credit.
  - Only REDIRECT may withdraw an ungranted request.
- On IMEM_GNT, PC_EN=1 and the issued address is latched. The FSM goes to WAIT.
- On IMEM_RVALID in WAIT, {latched address, IMEM_RDATA} is pushed to the queue.
- On IMEM_RVALID in DRAIN, the data is dropped and the FSM goes to IDLE. A new request may issue that same cycle.
- On REDIRECT:
  - PC_EN=1.
  - The queue is flushed; INST_VALID is 0 next cycle.
  - IMEM_REQ is forced to 0.
  - WAIT goes to DRAIN. If IMEM_RVALID arrives that same cycle, the data is dropped and the FSM goes to IDLE.
  - REQ goes to IDLE.
- REDIRECT coinciding with GNT cannot occur, because REQ is gated off.
- REDIRECT in DRAIN keeps DRAIN.
- Push and pop in the same cycle leave occ unchanged.
- Pointers wrap modulo DEPTH.
- With the queue full, no push can occur, because of credit.

## Timing
- Reset (async assert, sync release): state IDLE, occ 0, IMEM_REQ 0, PC_EN 0, INST_VALID 0, INST 0, INST_PC 0, counters 0.
- First IMEM_REQ occurs in the first cycle after RST_N releases, at PC_IF=0.
- Minimum latency: grant at cycle t, RVALID at t+1, INST_VALID at t+2. There is no bypass; queue outputs are registered.
- Steady state with single-cycle IMEM and INST_READY=1: one instruction per cycle.
- The INST_READY → IMEM_REQ combinational path is permitted.
- INST and INST_PC stay stable while INST_VALID=1 and INST_READY=0.

## Configuration
- IFETCH_PERF_EN defined:
  - PERF_FETCHED increments on each pop.
  - PERF_FLUSHED increments by the number of queue entries flushed, plus 1 for each response dropped in DRAIN.
  - Both counters wrap at 2^32.
- IFETCH_PERF_EN undefined: both ports are tied to 0 and no counter logic is generated.

## Structure
- Package ifetch_pkg holds:
  - the FSM state enum (IDLE, REQ, WAIT, DRAIN);
  - queue entry type {pc[31:0], inst[31:0]};
  - constant RESET_PC = 32'd0.
- One sub-module, ifetch_queue: DEPTH-entry FIFO with push, pop, flush, count and registered head outputs.

## Test plan
- Reset mid-WAIT, RST_N low one cycle: all outputs 0 immediately. After release, IMEM_REQ=1 with IMEM_ADDR=0.
- Single-cycle IMEM, INST_READY=1, PC stepping 0,4,8: INST_PC sequence 0,4,8 with INST matching. INST_VALID continuous from cycle t+2.
- INST_READY=0 with DEPTH=2: exactly two requests granted, then IMEM_REQ=0. Raising READY resumes fetching the following cycle.
- GNT delayed 3 cycles: IMEM_REQ and IMEM_ADDR held stable for 3 cycles, and PC_EN pulses only on the grant cycle.
- REDIRECT while in WAIT with 1 entry queued: queue flushed, and the late response (0x1234_5678) never appears on INST. The next request is at the target; PERF_FLUSHED=2 with IFETCH_PERF_EN.
- REDIRECT in the same cycle as IMEM_RVALID: data dropped, and a new IMEM_REQ is issued the next cycle.
